cpuout_reply_arb: RTL and testbench

//  Shares the single CPU-to-host reply FIFO write port among NUM_REQ reply sources on the Wishbone clock.

---
 rtl/cpuout_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/cpuout_reply_arb.sv | 162 ++++++++++++++++
 tb/tb_cpuout_reply_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuout_arb_pkg.sv
// ============================================================================
// cpuout_arb_pkg : shared types and helpers for the CPU reply FIFO arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package cpuout_arb_pkg;

    localparam int WC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_XFER   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at or after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = IDX_W'(cand);
                grant_o[cand]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpuout_reply_arb.sv
// ============================================================================
// cpuout_reply_arb : round-robin packet arbiter for the CPU-to-host reply FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module cpuout_reply_arb
    import cpuout_arb_pkg::*;
#(
    parameter int FT_DATA_WIDTH = 32,
    parameter int NUM_REQ       = 2,
    parameter int WC_PULSE_LEN  = 4
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [8*NUM_REQ-1:0]               req_len_i,
    input  logic [FT_DATA_WIDTH*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [NUM_REQ-1:0]                 req_grant_o,
    output logic [NUM_REQ-1:0]                 req_done_o,
    output logic [FT_DATA_WIDTH-1:0]           fifoout_data_o,
    output logic                               fifoout_wr_o,
    input  logic                               fifoout_full_i,
    output logic [WC_W-1:0]                    fifoout_wc_o,
    output logic                               fifoout_wcen_o,
    output logic                               aborted_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PC_W  = (WC_PULSE_LEN > 1) ? $clog2(WC_PULSE_LEN) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [WC_W-1:0]     len_q, len_d;
    logic [WC_W-1:0]     cnt_q, cnt_d;
    logic [WC_W-1:0]     wc_q, wc_d;
    logic [PC_W-1:0]     pc_q, pc_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                own_valid;
    logic                pc_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign own_valid    = req_valid_i[idx_q];
    assign pc_last      = (pc_q == PC_W'(WC_PULSE_LEN - 1));
    assign fifoout_wc_o = wc_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wc_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        gnt_d          = gnt_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        wc_d           = wc_q;
        pc_d           = pc_q;
        req_ready_o    = '0;
        req_grant_o    = '0;
        req_done_o     = '0;
        fifoout_data_o = '0;
        fifoout_wr_o   = 1'b0;
        fifoout_wcen_o = 1'b0;
        aborted_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arb_any) begin
                    idx_d   = arb_idx;
                    gnt_d   = arb_grant;
                    len_d   = req_len_i[arb_idx*WC_W +: WC_W];
                    ptr_d   = IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
                    state_d = (req_len_i[arb_idx*WC_W +: WC_W] == '0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                req_grant_o    = gnt_q;
                fifoout_data_o = req_data_i[idx_q*FT_DATA_WIDTH +: FT_DATA_WIDTH];
                if (!own_valid) begin
                    // Requester withdrew: publish what already reached the FIFO.
                    aborted_o = 1'b1;
                    state_d   = (cnt_q != '0) ? ST_COMMIT : ST_DONE;
                end else if (!fifoout_full_i) begin
                    fifoout_wr_o = 1'b1;
                    req_ready_o  = gnt_q;
                    cnt_d        = cnt_q + WC_W'(1);
                    if (cnt_q + WC_W'(1) == len_q) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                req_grant_o = gnt_q;
                req_done_o  = gnt_q;
                wc_d        = cnt_q;
                pc_d        = '0;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                fifoout_wcen_o = 1'b1;
                pc_d           = pc_q + PC_W'(1);
                if (pc_last) begin
                    pc_d    = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Low gap lets the slow-side edge detector see every pulse.
                pc_d = pc_q + PC_W'(1);
                if (pc_last) begin
                    pc_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                req_grant_o = gnt_q;
                req_done_o  = gnt_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpuout_reply_arb.sv
// ============================================================================
// tb_cpuout_reply_arb : scoreboard bench with a packet-level round-robin model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpuout_reply_arb;

    localparam int NR   = 3;
    localparam int DW   = 32;
    localparam int PL   = 4;
    localparam int NOAB = 1000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      valid = '0;
    logic [8*NR-1:0]    lenv  = '0;
    logic [DW*NR-1:0]   datav = '0;
    logic [NR-1:0]      ready, grant, done;
    logic [DW-1:0]      fdata;
    logic               fwr, fwcen, abort;
    logic               full = 1'b0;
    logic [7:0]         fwc;

    always #5 clk = ~clk;

    cpuout_reply_arb #(.FT_DATA_WIDTH(DW), .NUM_REQ(NR), .WC_PULSE_LEN(PL)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .req_valid_i    (valid),
        .req_len_i      (lenv),
        .req_data_i     (datav),
        .req_ready_o    (ready),
        .req_grant_o    (grant),
        .req_done_o     (done),
        .fifoout_data_o (fdata),
        .fifoout_wr_o   (fwr),
        .fifoout_full_i (full),
        .fifoout_wc_o   (fwc),
        .fifoout_wcen_o (fwcen),
        .aborted_o      (abort)
    );

    typedef struct { int r; int len; int ab; int seq; } pkt_t;
    typedef struct { int r; logic [31:0] d; } wexp_t;

    pkt_t  pend[$];
    wexp_t exp_w[$];
    int    exp_wc[$];
    int    exp_d[$];
    int    exp_a[$];

    int checks = 0;
    int passes = 0;
    int ptr_m  = 0;
    int seq_n  = 0;
    logic [31:0] salt;

    pkt_t cur[NR];
    bit   act[NR];
    bit   vl[NR];
    int   widx[NR];
    int   trig_r = -1, trig_w = 0, full_cnt = 0;
    bit   rnd_full = 1'b0;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [NR-1:0] oh(input int r);
        logic [NR-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] word(input int seq, input int i);
        logic [31:0] s, x;
        s = seq;
        x = i;
        return (s << 12) ^ x ^ salt;
    endfunction

    task automatic add(input int r, input int len, input int ab);
        pkt_t p;
        p.r = r; p.len = len; p.ab = ab; p.seq = seq_n;
        seq_n++;
        pend.push_back(p);
    endtask

    // Packet-level reference: serve pending packets in round-robin order.
    task automatic plan();
        pkt_t q[$];
        pkt_t p;
        int pick, pi, n;
        q = pend;
        while (q.size() > 0) begin
            pick = -1; pi = -1;
            for (int k = 0; k < NR && pick < 0; k++) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (pick < 0 && q[j].r == (ptr_m + k) % NR) begin
                        pick = q[j].r; pi = j;
                    end
                end
            end
            p = q[pi];
            q.delete(pi);
            n = (p.ab < p.len) ? p.ab : p.len;
            for (int i = 0; i < n; i++) exp_w.push_back('{p.r, word(p.seq, i)});
            if (p.ab < p.len) exp_a.push_back(p.r);
            if (n > 0) exp_wc.push_back(n);
            exp_d.push_back(p.r);
            ptr_m = (pick + 1) % NR;
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            valid[r]          = vl[r];
            lenv[r*8 +: 8]    = act[r] ? 8'(cur[r].len) : 8'd0;
            datav[r*DW +: DW] = (act[r] && widx[r] < cur[r].len) ? word(cur[r].seq, widx[r]) : '0;
        end
    endtask

    task automatic step();
        logic [NR-1:0] s_rdy, s_done;
        bit found;
        @(negedge clk);
        s_rdy  = ready;
        s_done = done;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (s_rdy[r]) widx[r]++;
            if (s_done[r]) begin act[r] = 1'b0; vl[r] = 1'b0; end
            if (act[r] && vl[r] && cur[r].ab < cur[r].len && widx[r] == cur[r].ab && grant[r])
                vl[r] = 1'b0;
            if (!act[r]) begin
                found = 1'b0;
                for (int j = 0; j < pend.size(); j++) begin
                    if (!found && pend[j].r == r) begin
                        cur[r] = pend[j];
                        pend.delete(j);
                        found = 1'b1;
                    end
                end
                if (found) begin act[r] = 1'b1; vl[r] = 1'b1; widx[r] = 0; end
            end
        end
        if (trig_r >= 0 && act[trig_r] && widx[trig_r] == trig_w) begin
            full_cnt = 5; trig_r = -1;
        end
        full = (full_cnt > 0) || (rnd_full && $urandom_range(0, 3) == 0);
        if (full_cnt > 0) full_cnt--;
        drive();
    endtask

    task automatic clear_drv();
        pend.delete();
        for (int r = 0; r < NR; r++) begin act[r] = 1'b0; vl[r] = 1'b0; widx[r] = 0; end
        full_cnt = 0; trig_r = -1; full = 1'b0;
        drive();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_drv();
        repeat (2) step();
        rst = 1'b0;
        ptr_m = 0;
    endtask

    function automatic bit busy();
        bit b;
        b = (pend.size() > 0) || (exp_w.size() > 0) || (exp_d.size() > 0) ||
            (exp_wc.size() > 0) || (exp_a.size() > 0);
        for (int r = 0; r < NR; r++) b = b || act[r];
        return b;
    endfunction

    task automatic run_batch(input int budget);
        int n;
        n = 0;
        plan();
        while (busy() && n < budget) begin step(); n++; end
        if (n >= budget) begin
            chk(1'b0, "batch_timeout", $sformatf("still busy after %0d cycles", n));
            exp_w.delete(); exp_wc.delete(); exp_d.delete(); exp_a.delete();
            reset_dut();
        end else begin
            repeat (2*PL + 3) step();
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents an output.
    bit   in_pulse = 1'b0;
    int   hi_cnt = 0, since = -1;
    logic [7:0] wc_hold = '0;
    logic [NR-1:0] prev_grant = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0; hi_cnt = 0; since = -1; prev_grant = '0;
        end else begin
            if (fwr) begin
                if (exp_w.size() == 0) chk(1'b0, "write", $sformatf("unexpected write data=%h", fdata));
                else begin
                    wexp_t e;
                    e = exp_w.pop_front();
                    chk(fdata == e.d && grant == oh(e.r), "write",
                        $sformatf("data=%h grant=%b, required data=%h grant=%b", fdata, grant, e.d, oh(e.r)));
                end
            end
            if (full) chk(!fwr, "wr_while_full", $sformatf("wr=%b, required 0", fwr));
            if (done != '0) begin
                if (exp_d.size() == 0) chk(1'b0, "done", $sformatf("unexpected done=%b", done));
                else begin
                    int r;
                    r = exp_d.pop_front();
                    chk(done == oh(r), "done", $sformatf("done=%b, required %b", done, oh(r)));
                end
            end
            if (abort) begin
                if (exp_a.size() == 0) chk(1'b0, "abort", $sformatf("unexpected abort grant=%b", grant));
                else begin
                    int r;
                    r = exp_a.pop_front();
                    chk(grant == oh(r), "abort", $sformatf("grant=%b, required %b", grant, oh(r)));
                end
            end
            if (fwcen && !in_pulse) begin
                in_pulse = 1'b1; hi_cnt = 1; wc_hold = fwc;
                if (exp_wc.size() == 0) chk(1'b0, "wc", $sformatf("unexpected wcen, wc=%0d", fwc));
                else begin
                    int w;
                    w = exp_wc.pop_front();
                    chk(int'(fwc) == w, "wc", $sformatf("wc=%0d, required %0d", fwc, w));
                end
            end else if (fwcen) begin
                hi_cnt++;
                chk(fwc == wc_hold, "wc_stable", $sformatf("wc=%0d, required %0d", fwc, wc_hold));
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                chk(hi_cnt == PL, "wcen_len", $sformatf("high %0d cycles, required %0d", hi_cnt, PL));
                since = 1;
            end else if (since >= 0) begin
                since++;
            end
            if (grant != '0 && prev_grant == '0 && since >= 0) begin
                chk(since >= PL + 2, "gap", $sformatf("grant %0d cycles after pulse, required >= %0d", since, PL + 2));
                since = -1;
            end
            prev_grant = grant;
        end
    end

    initial begin
        int np, r, ln, ab, budget;
        salt = $urandom;
        clear_drv();
        rst = 1'b1;
        step();
        chk({ready, grant, done, fdata, fwr, fwc, fwcen, abort} == '0, "reset_outputs",
            $sformatf("ready=%b grant=%b done=%b wr=%b wc=%0d wcen=%b", ready, grant, done, fwr, fwc, fwcen));
        reset_dut();

        add(0, 3, NOAB);
        run_batch(200);

        reset_dut();
        add(0, 2, NOAB); add(1, 2, NOAB); add(0, 2, NOAB);
        run_batch(300);

        trig_r = 1; trig_w = 2;
        add(1, 5, NOAB);
        run_batch(200);

        add(2, 255, NOAB);
        run_batch(800);
        add(0, 0, NOAB);
        run_batch(100);
        add(0, 1, NOAB); add(1, 1, NOAB);
        run_batch(200);

        add(0, 5, 2); add(1, 2, NOAB); add(2, 3, 0);
        run_batch(300);

        // Reset in the middle of the wcen pulse.
        add(0, 1, NOAB);
        plan();
        begin
            int seen, n;
            seen = 0; n = 0;
            while (seen < 2 && n < 100) begin step(); n++; if (fwcen) seen++; end
            chk(seen == 2, "reach_hold", $sformatf("wcen seen %0d cycles, required 2", seen));
        end
        rst = 1'b1;
        step();
        chk(!fwcen && grant == '0 && fwc == 8'd0, "reset_in_hold",
            $sformatf("wcen=%b grant=%b wc=%0d, required 0/0/0", fwcen, grant, fwc));
        rst = 1'b0;
        ptr_m = 0;
        clear_drv();
        add(0, 1, NOAB);
        run_batch(100);

        rnd_full = 1'b1;
        for (int b = 0; b < 25; b++) begin
            np = $urandom_range(1, 4);
            budget = 200;
            for (int k = 0; k < np; k++) begin
                r  = $urandom_range(0, NR - 1);
                ln = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
                ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : NOAB;
                add(r, ln, ab);
                budget += ln * 4 + 30;
            end
            run_batch(budget);
        end
        rnd_full = 1'b0;

        chk(exp_w.size() == 0 && exp_wc.size() == 0 && exp_d.size() == 0 && exp_a.size() == 0,
            "drained", $sformatf("left w=%0d wc=%0d d=%0d a=%0d, required all 0",
                                 exp_w.size(), exp_wc.size(), exp_d.size(), exp_a.size()));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
